load_station_array: RTL and testbench
=====================================

# load_station_array

Parametrised load reservation-station array for the Tomasulo float core. It holds up to `N_ST` pending loads and captures base-address operands by snooping the common data bus (CDB) and its own results. It issues the oldest ready load to memory over a valid/ack handshake and presents each result for CDB broadcast, holding it until the broadcast is accepted. It sits beside the adder and multiplier station blocks, between dispatch, the memory port and the CDB arbiter.

## Interface
- `N_ST`, 4: number of load stations (2..16).
- `DW`, 16: data and address width.
- `TW`, 4: tag and register-index width.
- `TAG_BASE`, 2: tag of station 0; station i has tag `TAG_BASE+i`.
- `TAG_NONE`, all ones: "no tag" / "full" value.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `alloc_valid` in 1: dispatch writes a new load this cycle.
- `alloc_reg` in TW: destination register.
- `alloc_base` in DW: base value; meaningful only when `alloc_base_ready`=1.
- `alloc_base_ready` in 1: base value is valid.
- `alloc_base_src` in TW: producer tag of the base when not ready.
- `alloc_offset` in DW: immediate offset.
- `next_tag` out TW: tag the next allocation receives; `TAG_NONE` when full.
- `free_count` out clog2(N_ST+1): number of empty stations.
- `cdb_valid`, `cdb_tag`, `cdb_data` in 1/TW/DW: broadcast from the other units.
- `mem_req` out 1, `mem_addr` out DW: load request; held until acked.
- `mem_ack` in 1, `mem_data` in DW: one-cycle response.
- `load_out_valid` out 1; `load_out_data` out DW; `load_out_tag` out TW; `load_out_reg` out TW: result offered to the CDB.
- `load_out_ack` in 1: the CDB arbiter takes the result this cycle.

## Operation
- Each station holds: busy, reg, base, base_ready, base_src, offset, and an age rank.
- Allocation: on `alloc_valid` with `free_count`>0, the entry is written into the lowest-index free station, which is the station `next_tag` names. On `alloc_valid` while full, the request is ignored and no state changes.
- Snoop: every busy station with base_ready=0 and base_src==`cdb_tag` captures `cdb_data` when `cdb_valid`=1. The same applies to the block's own result when `load_out_valid & load_out_ack`.
- Allocation bypass: if the allocated base_src matches a snooped tag in the same cycle, the entry is written already ready, holding the snooped data.
- Eligibility: a station is eligible when busy, base_ready=1 and not already issued.
- Selection: the eligible station allocated earliest wins, tracked by an age matrix. Lowest-index-wins is not permitted.
- Address: `mem_addr` = base + offset, modulo 2^DW, with no overflow flag.
- FSM states:
  - IDLE: if any station is eligible, latch the winner's index and address, then go to REQ.
  - REQ: `mem_req`=1. On `mem_ack`, latch `mem_data` and go to RESULT.
  - RESULT: `load_out_valid`=1, with the tag, reg and data stable. On `load_out_ack`, free the station, clear its age row and go to IDLE.
- Exactly one load is outstanding at a time.
- `mem_ack` outside REQ is ignored.
- An issued station is not freed until its result is acked, so its tag stays reserved.
- Simultaneous free and allocation are permitted in the same cycle. The freed slot counts as free only from the next cycle.

## Timing
- Reset values:
  - all stations idle; FSM in IDLE;
  - `mem_req`=0, `mem_addr`=0;
  - `load_out_valid`=0, `load_out_data`=0, `load_out_tag`=`TAG_NONE`, `load_out_reg`=0;
  - `next_tag`=`TAG_BASE`, `free_count`=`N_ST`.
- Reset mid-operation: `reset` in any state aborts. A `mem_ack` arriving after reset is dropped.
- Minimum latency for an allocation with base already ready:
  - cycle 0: `alloc_valid`;
  - cycle 1: entry visible and selected;
  - cycle 2: `mem_req` high;
  - cycle 2: earliest `mem_ack`;
  - cycle 3: `load_out_valid`.
- `next_tag` and `free_count` are combinational from registered state.
- Captured snoop data makes a station eligible in the cycle after capture.

## Structure
- A shared package `lsa_pkg` holds the station struct, the FSM state enum, and the `TAG_NONE` and tag-base helpers.
- Sub-module `age_matrix`: an N_ST×N_ST set/clear matrix with a request vector input and a one-hot oldest-grant output.

## Test plan
- Ready-base allocation, base=0x0100, offset=0x0004 -> `mem_addr`=0x0104 in cycle 2. After `mem_ack` with 0xBEEF in cycle 2, `load_out_valid`=1 in cycle 3 with tag 2 and data 0xBEEF.
- Allocate station 0 waiting on tag 7, then station 1 ready. Then send CDB tag 7 with 0x0010 -> station 1 issues first. Station 0 issues only after station 1's result is acked.
- Fill all 4 stations -> `next_tag`=0xF and `free_count`=0. A fifth `alloc_valid` changes nothing.
- Allocation with base_src=5 in the same cycle as CDB tag 5 carrying 0x0200 -> the entry is written ready, and `mem_addr` = 0x0200 + offset.
- Hold `load_out_ack`=0 for 5 cycles -> the result stays stable and no new `mem_req` is raised. On ack, a dependent station waiting on tag 2 captures the data.
- Base 0xFFF0, offset 0x0020 -> `mem_addr`=0x0010. Then assert `reset` in REQ -> `mem_req`=0 next cycle and a late `mem_ack` has no effect.

Source files
------------

// File: rtl/lsa_pkg.sv
// Shared types and helpers for the load reservation-station array:
// station status flags, issue FSM states and tag arithmetic.
package lsa_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RESULT = 2'd2
  } lsa_state_e;

  typedef struct packed {
    logic busy;
    logic base_ready;
    logic issued;
  } lsa_flags_t;

  function automatic int unsigned tag_none_val(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

  function automatic int unsigned station_tag(input int unsigned tag_base, input int unsigned idx);
    return tag_base + idx;
  endfunction

endpackage

// File: rtl/age_matrix.sv
// Allocation-order tracker: age_q[i][j]=1 means station i was allocated before j.
// Grants the single requester that no other requester is older than.
module age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] set_i,
  input  logic [N-1:0] clr_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic [N-1:0][N-1:0] age_q;
  logic [N-1:0][N-1:0] age_d;
  logic [N-1:0]        blocked_s;

  // New entry becomes youngest: its row clears, every other row marks it as younger.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        age_d[i][j] = clr_i[i] ? 1'b0 : (set_i[j] ? 1'b1 : age_q[i][j]);
      end
    end
  end

  // Oldest-requester grant.
  always_comb begin
    blocked_s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        blocked_s[i] = blocked_s[i] | (req_i[j] & age_q[j][i]);
      end
    end
    gnt_o = req_i & ~blocked_s;
  end

  // Matrix state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/load_station_array.sv
// Load reservation-station array: captures base operands from the CDB, issues
// the oldest ready load to memory and offers its result back to the CDB.
module load_station_array
  import lsa_pkg::*;
#(
  parameter int N_ST     = 4,
  parameter int DW       = 16,
  parameter int TW       = 4,
  parameter int TAG_BASE = 2,
  parameter logic [TW-1:0] TAG_NONE = TW'(tag_none_val(TW))
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_valid,
  input  logic [TW-1:0]               alloc_reg,
  input  logic [DW-1:0]               alloc_base,
  input  logic                        alloc_base_ready,
  input  logic [TW-1:0]               alloc_base_src,
  input  logic [DW-1:0]               alloc_offset,
  output logic [TW-1:0]               next_tag,
  output logic [$clog2(N_ST+1)-1:0]   free_count,
  input  logic                        cdb_valid,
  input  logic [TW-1:0]               cdb_tag,
  input  logic [DW-1:0]               cdb_data,
  output logic                        mem_req,
  output logic [DW-1:0]               mem_addr,
  input  logic                        mem_ack,
  input  logic [DW-1:0]               mem_data,
  output logic                        load_out_valid,
  output logic [DW-1:0]               load_out_data,
  output logic [TW-1:0]               load_out_tag,
  output logic [TW-1:0]               load_out_reg,
  input  logic                        load_out_ack
);

  localparam int IW = $clog2(N_ST);
  localparam int CW = $clog2(N_ST + 1);

  function automatic logic [TW-1:0] tag_of(input logic [IW-1:0] idx);
    return TW'(station_tag(TAG_BASE, 32'(idx)));
  endfunction

  lsa_state_e    state_q, state_d;
  lsa_flags_t    flags_q [N_ST];
  lsa_flags_t    flags_d [N_ST];
  logic [TW-1:0] reg_q   [N_ST];
  logic [TW-1:0] reg_d   [N_ST];
  logic [TW-1:0] src_q   [N_ST];
  logic [TW-1:0] src_d   [N_ST];
  logic [DW-1:0] base_q  [N_ST];
  logic [DW-1:0] base_d  [N_ST];
  logic [DW-1:0] off_q   [N_ST];
  logic [DW-1:0] off_d   [N_ST];

  logic [IW-1:0] sel_q;
  logic [DW-1:0] mem_addr_q, out_data_q;
  logic [TW-1:0] out_tag_q, out_reg_q;
  logic          out_valid_q;

  logic [N_ST-1:0] free_vec_s, elig_s, gnt_s, alloc_oh_s, free_oh_s;
  logic [IW-1:0]   alloc_idx_s, gnt_idx_s;
  logic [CW-1:0]   free_cnt_s;
  logic            any_free_s, alloc_fire_s, own_fire_s, issue_s;
  logic            cdb_hit_a_s, own_hit_a_s, alloc_ready_s;
  logic [DW-1:0]   alloc_bval_s, addr_s;

  assign any_free_s   = |free_vec_s;
  assign alloc_fire_s = alloc_valid & any_free_s;
  assign own_fire_s   = out_valid_q & load_out_ack;
  assign issue_s      = (state_q == S_IDLE) & (|elig_s);
  // A not-yet-ready base can be satisfied by a broadcast in the allocation cycle.
  assign cdb_hit_a_s   = cdb_valid & (alloc_base_src == cdb_tag);
  assign own_hit_a_s   = own_fire_s & (alloc_base_src == out_tag_q);
  assign alloc_ready_s = alloc_base_ready | cdb_hit_a_s | own_hit_a_s;
  assign alloc_bval_s  = alloc_base_ready ? alloc_base :
                         (cdb_hit_a_s ? cdb_data : (own_hit_a_s ? out_data_q : alloc_base));

  assign next_tag       = any_free_s ? tag_of(alloc_idx_s) : TAG_NONE;
  assign free_count     = free_cnt_s;
  assign mem_req        = (state_q == S_REQ);
  assign mem_addr       = mem_addr_q;
  assign load_out_valid = out_valid_q;
  assign load_out_data  = out_data_q;
  assign load_out_tag   = out_tag_q;
  assign load_out_reg   = out_reg_q;

  // Free-slot scan (lowest index first), eligibility and one-hot update vectors.
  always_comb begin
    free_vec_s  = '0;
    elig_s      = '0;
    free_cnt_s  = '0;
    alloc_idx_s = '0;
    for (int i = N_ST - 1; i >= 0; i--) begin
      free_vec_s[i] = ~flags_q[i].busy;
      elig_s[i]     = flags_q[i].busy & flags_q[i].base_ready & ~flags_q[i].issued;
      free_cnt_s    = free_cnt_s + CW'(free_vec_s[i]);
      alloc_idx_s   = free_vec_s[i] ? IW'(i) : alloc_idx_s;
    end
    alloc_oh_s = '0;
    free_oh_s  = '0;
    for (int i = 0; i < N_ST; i++) begin
      alloc_oh_s[i] = alloc_fire_s & (alloc_idx_s == IW'(i));
      free_oh_s[i]  = own_fire_s & (sel_q == IW'(i));
    end
  end

  age_matrix #(.N(N_ST)) u_age (
    .clk   (clk),
    .reset (reset),
    .set_i (alloc_oh_s),
    .clr_i (alloc_oh_s | free_oh_s),
    .req_i (elig_s),
    .gnt_o (gnt_s)
  );

  // Grant index and the winner's effective address.
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < N_ST; i++) begin
      gnt_idx_s = gnt_s[i] ? IW'(i) : gnt_idx_s;
    end
    addr_s = base_q[gnt_idx_s] + off_q[gnt_idx_s];
  end

  // Per-station next state: allocate, snoop, free on result ack, mark issued.
  always_comb begin
    for (int i = 0; i < N_ST; i++) begin
      flags_d[i] = flags_q[i];
      reg_d[i]   = reg_q[i];
      src_d[i]   = src_q[i];
      base_d[i]  = base_q[i];
      off_d[i]   = off_q[i];
      if (alloc_oh_s[i]) begin
        flags_d[i] = '{busy: 1'b1, base_ready: alloc_ready_s, issued: 1'b0};
        reg_d[i]   = alloc_reg;
        src_d[i]   = alloc_base_src;
        base_d[i]  = alloc_bval_s;
        off_d[i]   = alloc_offset;
      end else if (flags_q[i].busy && !flags_q[i].base_ready && cdb_valid && (src_q[i] == cdb_tag)) begin
        flags_d[i].base_ready = 1'b1;
        base_d[i]             = cdb_data;
      end else if (flags_q[i].busy && !flags_q[i].base_ready && own_fire_s && (src_q[i] == out_tag_q)) begin
        flags_d[i].base_ready = 1'b1;
        base_d[i]             = out_data_q;
      end else if (free_oh_s[i]) begin
        flags_d[i] = '0;
      end else if (issue_s && gnt_s[i]) begin
        flags_d[i].issued = 1'b1;
      end else begin
        flags_d[i] = flags_q[i];
      end
    end
  end

  // Issue FSM next state: one load outstanding from issue until result ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (issue_s)    state_d = S_REQ;    else state_d = S_IDLE;
      S_REQ:    if (mem_ack)    state_d = S_RESULT; else state_d = S_REQ;
      S_RESULT: if (own_fire_s) state_d = S_IDLE;   else state_d = S_RESULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, station storage and registered memory/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= TAG_NONE;
      out_reg_q   <= '0;
      for (int i = 0; i < N_ST; i++) begin
        flags_q[i] <= '0;
        reg_q[i]   <= '0;
        src_q[i]   <= '0;
        base_q[i]  <= '0;
        off_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      reg_q   <= reg_d;
      src_q   <= src_d;
      base_q  <= base_d;
      off_q   <= off_d;
      if (issue_s) begin
        sel_q      <= gnt_idx_s;
        mem_addr_q <= addr_s;
      end
      if ((state_q == S_REQ) && mem_ack) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem_data;
        out_tag_q   <= tag_of(sel_q);
        out_reg_q   <= reg_q[sel_q];
      end else if (own_fire_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_station_array.sv
// Scoreboard bench for load_station_array: a load-level reference model pushes
// expected memory addresses and results; a monitor pops and compares them.
module tb_load_station_array;

  localparam int N  = 4;
  localparam int TB = 2;

  logic        clk, reset;
  logic        alloc_valid, alloc_base_ready;
  logic [3:0]  alloc_reg, alloc_base_src, cdb_tag, next_tag, load_out_tag, load_out_reg;
  logic [15:0] alloc_base, alloc_offset, cdb_data, mem_addr, mem_data, load_out_data;
  logic [2:0]  free_count;
  logic        cdb_valid, mem_req, mem_ack, load_out_valid, load_out_ack;

  load_station_array #(.N_ST(4), .DW(16), .TW(4), .TAG_BASE(2)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .alloc_base(alloc_base),
    .alloc_base_ready(alloc_base_ready), .alloc_base_src(alloc_base_src), .alloc_offset(alloc_offset),
    .next_tag(next_tag), .free_count(free_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .load_out_valid(load_out_valid), .load_out_data(load_out_data),
    .load_out_tag(load_out_tag), .load_out_reg(load_out_reg), .load_out_ack(load_out_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=missing required=event", name);
  endtask

  // ---------------- reference model (load-level view) ----------------
  typedef struct {
    logic [3:0]  tag;
    logic [3:0]  r;
    logic [15:0] d;
  } res_t;

  logic [15:0] exp_addr_q[$];
  res_t        exp_res_q[$];

  bit          m_busy[N], m_rdy[N], m_iss[N];
  logic [15:0] m_base[N], m_off[N];
  logic [3:0]  m_reg[N], m_src[N];
  int          m_seq[N];
  int          seq_ctr, m_phase, m_sel;
  bit          m_ov;
  logic [15:0] m_od;
  logic [3:0]  m_ot, m_or;

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_free_cnt();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_step();
    bit own;
    int lf, win;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_rdy[i] = 0; m_iss[i] = 0;
      end
      seq_ctr = 0; m_phase = 0; m_sel = 0; m_ov = 0;
      m_od = 16'h0; m_ot = 4'hF; m_or = 4'h0;
      exp_addr_q.delete();
      exp_res_q.delete();
    end else begin
      own = m_ov && load_out_ack;
      lf  = m_lowest_free();
      win = -1;
      if (m_phase == 0)
        for (int i = 0; i < N; i++)
          if (m_busy[i] && m_rdy[i] && !m_iss[i] && (win < 0 || m_seq[i] < m_seq[win])) win = i;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && !m_rdy[i]) begin
          if (cdb_valid && m_src[i] == cdb_tag) begin m_rdy[i] = 1; m_base[i] = cdb_data; end
          else if (own && m_src[i] == m_ot) begin m_rdy[i] = 1; m_base[i] = m_od; end
        end
      end
      if (alloc_valid && lf >= 0) begin
        m_busy[lf] = 1; m_iss[lf] = 0; m_reg[lf] = alloc_reg; m_src[lf] = alloc_base_src;
        m_off[lf] = alloc_offset; m_seq[lf] = seq_ctr++;
        if (alloc_base_ready) begin m_rdy[lf] = 1; m_base[lf] = alloc_base; end
        else if (cdb_valid && alloc_base_src == cdb_tag) begin m_rdy[lf] = 1; m_base[lf] = cdb_data; end
        else if (own && alloc_base_src == m_ot) begin m_rdy[lf] = 1; m_base[lf] = m_od; end
        else m_rdy[lf] = 0;
      end
      if (m_phase == 0 && win >= 0) begin
        m_iss[win] = 1; m_sel = win; m_phase = 1;
        exp_addr_q.push_back(16'(m_base[win] + m_off[win]));
      end else if (m_phase == 1 && mem_ack) begin
        m_phase = 2; m_ov = 1; m_od = mem_data;
        m_ot = 4'(TB + m_sel); m_or = m_reg[m_sel];
        exp_res_q.push_back('{tag: m_ot, r: m_or, d: m_od});
      end else if (m_phase == 2 && own) begin
        m_busy[m_sel] = 0; m_iss[m_sel] = 0; m_rdy[m_sel] = 0;
        m_ov = 0; m_phase = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  initial begin
    bit   req_seen = 0, res_seen = 0;
    res_t cur;
    int   lf;
    forever begin
      @(negedge clk);
      lf = m_lowest_free();
      chk("next_tag", 32'(next_tag), (lf < 0) ? 32'hF : 32'(TB + lf));
      chk("free_count", 32'(free_count), 32'(m_free_cnt()));
      chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
      chk("load_out_valid", 32'(load_out_valid), 32'(m_ov));
      if (mem_req && !req_seen) begin
        req_seen = 1;
        if (exp_addr_q.size() == 0) fail_evt("expected_mem_req");
        else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end else if (!mem_req) begin
        req_seen = 0;
      end
      if (load_out_valid) begin
        if (!res_seen) begin
          res_seen = 1;
          if (exp_res_q.size() == 0) begin
            fail_evt("expected_result");
            cur = '{tag: load_out_tag, r: load_out_reg, d: load_out_data};
          end else begin
            cur = exp_res_q.pop_front();
          end
        end
        chk("out_tag", 32'(load_out_tag), 32'(cur.tag));
        chk("out_reg", 32'(load_out_reg), 32'(cur.r));
        chk("out_data", 32'(load_out_data), 32'(cur.d));
      end else begin
        res_seen = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic alloc_in(input logic [3:0] r, input logic rdy, input logic [15:0] base,
                          input logic [3:0] src, input logic [15:0] off);
    alloc_valid = 1'b1; alloc_reg = r; alloc_base_ready = rdy;
    alloc_base = base; alloc_base_src = src; alloc_offset = off;
  endtask

  task automatic wait_req(input string name, input int maxc);
    int n = 0;
    while (!mem_req && n < maxc) begin step(); n++; end
    if (!mem_req) fail_evt(name);
  endtask

  task automatic serve(input string name, input logic [15:0] d, input logic [3:0] tag);
    mem_ack = 1'b1; mem_data = d;
    step();
    mem_ack = 1'b0;
    chk({name, "_valid"}, 32'(load_out_valid), 32'h1);
    chk({name, "_tag"}, 32'(load_out_tag), 32'(tag));
    chk({name, "_data"}, 32'(load_out_data), 32'(d));
    load_out_ack = 1'b1;
    step();
    load_out_ack = 1'b0;
  endtask

  task automatic drain(input string name, input int k, input int maxc);
    int cnt = 0, n = 0;
    while (cnt < k && n < maxc) begin
      mem_ack = mem_req; mem_data = 16'($urandom);
      load_out_ack = load_out_valid;
      if (load_out_valid) cnt++;
      step(); n++;
    end
    mem_ack = 1'b0; load_out_ack = 1'b0;
    if (cnt < k) fail_evt(name);
  endtask

  int ext_tags[6] = '{0, 1, 6, 7, 8, 9};

  initial begin
    reset = 1'b1; alloc_valid = 1'b0; alloc_reg = '0; alloc_base = '0; alloc_base_ready = 1'b0;
    alloc_base_src = '0; alloc_offset = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    mem_ack = 1'b0; mem_data = '0; load_out_ack = 1'b0;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_out_valid", 32'(load_out_valid), 32'h0);
    chk("rst_out_data", 32'(load_out_data), 32'h0);
    chk("rst_out_tag", 32'(load_out_tag), 32'hF);
    chk("rst_out_reg", 32'(load_out_reg), 32'h0);
    chk("rst_next_tag", 32'(next_tag), 32'h2);
    chk("rst_free_count", 32'(free_count), 32'h4);
    reset = 1'b0;
    step();

    // minimum-latency ready-base load
    alloc_in(4'h1, 1'b1, 16'h0100, 4'h0, 16'h0004);
    step(); alloc_valid = 1'b0;
    step();
    chk("lat_mem_req_c2", 32'(mem_req), 32'h1);
    chk("lat_mem_addr_c2", 32'(mem_addr), 32'h0104);
    serve("lat_result_c3", 16'hBEEF, 4'h2);
    step();

    // older waiting load loses to a younger ready one until its operand arrives
    alloc_in(4'h3, 1'b0, 16'h0000, 4'h7, 16'h0008);
    step(); alloc_in(4'h4, 1'b1, 16'h0300, 4'h0, 16'h0004);
    step(); alloc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'h7; cdb_data = 16'h0010;
    step(); cdb_valid = 1'b0;
    wait_req("order_req1", 10);
    chk("order_addr1", 32'(mem_addr), 32'h0304);
    serve("order_res1", 16'h1111, 4'h3);
    wait_req("order_req2", 10);
    chk("order_addr2", 32'(mem_addr), 32'h0018);
    serve("order_res2", 16'h2222, 4'h2);

    // fill, then a rejected fifth allocation
    for (int k = 0; k < 4; k++) begin
      alloc_in(4'(k), 1'b0, 16'h0000, 4'h9, 16'(16 * k));
      step();
    end
    alloc_valid = 1'b0;
    chk("full_next_tag", 32'(next_tag), 32'hF);
    chk("full_free_count", 32'(free_count), 32'h0);
    alloc_in(4'hA, 1'b1, 16'h7000, 4'h0, 16'h0001);
    step(); alloc_valid = 1'b0;
    chk("full_free_count_after", 32'(free_count), 32'h0);
    cdb_valid = 1'b1; cdb_tag = 4'h9; cdb_data = 16'h1000;
    step(); cdb_valid = 1'b0;
    drain("full_drain", 4, 100);

    // allocation bypass from the CDB
    alloc_in(4'h5, 1'b0, 16'hDEAD, 4'h5, 16'h0030);
    cdb_valid = 1'b1; cdb_tag = 4'h5; cdb_data = 16'h0200;
    step(); alloc_valid = 1'b0; cdb_valid = 1'b0;
    wait_req("bypass_req", 10);
    chk("bypass_addr", 32'(mem_addr), 32'h0230);
    drain("bypass_drain", 1, 20);

    // result held under back-pressure, then forwarded to a dependent load
    alloc_in(4'h6, 1'b1, 16'h0040, 4'h0, 16'h0000);
    step(); alloc_in(4'h7, 1'b0, 16'h0000, 4'h2, 16'h0004);
    step(); alloc_valid = 1'b0;
    wait_req("hold_req", 10);
    mem_ack = 1'b1; mem_data = 16'h0500;
    step(); mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(load_out_valid), 32'h1);
      chk("hold_data", 32'(load_out_data), 32'h0500);
      chk("hold_tag", 32'(load_out_tag), 32'h2);
      chk("hold_no_req", 32'(mem_req), 32'h0);
      step();
    end
    load_out_ack = 1'b1;
    step(); load_out_ack = 1'b0;
    wait_req("dep_req", 10);
    chk("dep_addr", 32'(mem_addr), 32'h0504);
    drain("dep_drain", 1, 20);

    // address wrap, then reset while a request is pending
    alloc_in(4'h1, 1'b1, 16'hFFF0, 4'h0, 16'h0020);
    step(); alloc_valid = 1'b0;
    wait_req("wrap_req", 10);
    chk("wrap_addr", 32'(mem_addr), 32'h0010);
    reset = 1'b1;
    step(); reset = 1'b0; mem_ack = 1'b1; mem_data = 16'h1234;
    chk("rst_req_dropped", 32'(mem_req), 32'h0);
    step(); mem_ack = 1'b0;
    chk("late_ack_ignored", 32'(load_out_valid), 32'h0);
    chk("rst_free_all", 32'(free_count), 32'h4);

    // randomized traffic checked by the model
    for (int c = 0; c < 800; c++) begin
      reset            = ($urandom_range(0, 199) == 0);
      alloc_valid      = ($urandom_range(0, 9) < 4);
      alloc_reg        = 4'($urandom);
      alloc_base       = 16'($urandom);
      alloc_base_ready = ($urandom_range(0, 1) == 1);
      alloc_base_src   = 4'($urandom_range(0, 9));
      alloc_offset     = 16'($urandom);
      cdb_valid        = ($urandom_range(0, 9) < 3);
      cdb_tag          = 4'(ext_tags[$urandom_range(0, 5)]);
      cdb_data         = 16'($urandom);
      mem_ack          = ($urandom_range(0, 1) == 1);
      mem_data         = 16'($urandom);
      load_out_ack     = ($urandom_range(0, 1) == 1);
      step();
    end
    alloc_valid = 1'b0; cdb_valid = 1'b0; mem_ack = 1'b0; load_out_ack = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
